// File: rtl/spec_accum_48bit_pkg.sv
// Shared constants, FSM encoding and saturating-add helper for the 48-bit
// power-spectrum integrator.
package spec_accum_pkg;

    localparam int          DEF_BITWIDTH = 7;
    localparam int          CNT_W        = DEF_BITWIDTH + 2;
    localparam int          SUM_W        = 48;
    localparam logic [47:0] ACC_MAX      = 48'hFFFF_FFFF_FFFF;
    localparam int          PIPE_LAT     = 3;

    typedef enum logic {
        WAIT  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Returns {saturated, sum}; the sum is clamped to ACC_MAX on carry-out.
    function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[SUM_W]) begin
            return {1'b1, ACC_MAX};
        end
        return s;
    endfunction

endpackage

// File: rtl/spec_accum_48bit_if.sv
// Sample stream in / integrated stream out of the spectrum integrator,
// plus the acc_len control and status flags.
interface spec_accum_if
    import spec_accum_pkg::*;
#(
    parameter int CW    = CNT_W,
    parameter int IN_W  = 32,
    parameter int ACC_W = 16
);
    logic             en_sync_in;
    logic [CW-1:0]    cnt_sync_in;
    logic [IN_W-1:0]  pwr_in;
    logic [ACC_W-1:0] acc_len;

    logic [SUM_W-1:0] para_out;
    logic             en_sync_out;
    logic [CW-1:0]    cnt_sync_out;
    logic             acc_done;
    logic             ovf;
    logic             sync_err;

    modport master (
        output en_sync_in, cnt_sync_in, pwr_in, acc_len,
        input  para_out, en_sync_out, cnt_sync_out, acc_done, ovf, sync_err
    );

    modport slave (
        input  en_sync_in, cnt_sync_in, pwr_in, acc_len,
        output para_out, en_sync_out, cnt_sync_out, acc_done, ovf, sync_err
    );

endinterface

// File: rtl/spec_accum_48bit_ram.sv
// Simple dual-port RAM holding one running sum per FFT bin; write port and
// registered read port share clk so it maps onto a single block RAM.
module acc_ram_sdp #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 48
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/spec_accum_48bit.sv
// Integrates acc_len consecutive power spectra per bin into 48-bit sums and
// streams the final spectrum of each integration, 3 cycles after its input.
module spec_accum_48bit
    import spec_accum_pkg::*;
#(
    parameter int BITWIDTH  = 7,
    parameter int FFT_POINT = 512,
    parameter int IN_W      = 32,
    parameter int ACC_W     = 16
) (
    input logic         clk,
    input logic         rst,
    spec_accum_if.slave bus
);

    localparam int            CW       = BITWIDTH + 2;
    localparam logic [CW-1:0] LAST_BIN = CW'(FFT_POINT - 1);
    // Side-band tag travelling with each sample: {valid, start, last, bin}.
    localparam int            TAG_W    = CW + 3;
    localparam int            T_LAST   = CW;
    localparam int            T_START  = CW + 1;
    localparam int            T_VALID  = CW + 2;

    state_e           state_reg, state_next;
    logic [CW-1:0]    exp_bin_reg, exp_bin_next;
    logic [ACC_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic [ACC_W-1:0] len_q_reg, len_q_next;
    logic             sync_err_reg, sync_err_next;

    logic             in_order;
    logic             take;
    logic             start;
    logic [ACC_W-1:0] cur_frame;
    logic [ACC_W-1:0] cur_len;
    logic             cur_first;
    logic             cur_last;

    logic [TAG_W-1:0] tag_in;
    logic [TAG_W-1:0] tag_reg [PIPE_LAT-1];
    logic [TAG_W-1:0] tag_s2;
    logic             s1_first_reg;
    logic [IN_W-1:0]  s1_pwr_reg;
    logic [SUM_W-1:0] rd_data;
    logic [SUM_W:0]   add_res;
    logic [SUM_W-1:0] s2_sum_reg;
    logic             s2_sat_reg;
    logic             s2_valid;
    logic             s2_fire;
    logic [CW-1:0]    s2_bin;

    logic [SUM_W-1:0] para_out_reg;
    logic             en_out_reg;
    logic [CW-1:0]    cnt_out_reg;
    logic             acc_done_reg;
    logic             ovf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= WAIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        exp_bin_next   = exp_bin_reg;
        frame_cnt_next = frame_cnt_reg;
        len_q_next     = len_q_reg;
        sync_err_next  = sync_err_reg;
        take           = 1'b0;
        start          = 1'b0;
        cur_frame      = frame_cnt_reg;
        cur_len        = len_q_reg;
        in_order       = (state_reg == ACCUM) && (bus.cnt_sync_in == exp_bin_reg);

        if (bus.en_sync_in) begin
            if (in_order) begin
                take  = 1'b1;
                start = (exp_bin_reg == '0) && (frame_cnt_reg == '0);
            end else begin
                if (state_reg == ACCUM) begin
                    sync_err_next = 1'b1;
                end
                // A broken sequence landing on bin 0 is a valid fresh start.
                if (bus.cnt_sync_in == '0) begin
                    take  = 1'b1;
                    start = 1'b1;
                end else begin
                    state_next     = WAIT;
                    exp_bin_next   = '0;
                    frame_cnt_next = '0;
                end
            end
        end

        if (start) begin
            cur_frame  = '0;
            cur_len    = (bus.acc_len == '0) ? ACC_W'(1) : bus.acc_len;
            len_q_next = cur_len;
        end

        cur_first = (cur_frame == '0);
        cur_last  = (cur_frame == cur_len - ACC_W'(1));

        if (take) begin
            state_next = ACCUM;
            if (bus.cnt_sync_in == LAST_BIN) begin
                exp_bin_next   = '0;
                frame_cnt_next = cur_last ? '0 : cur_frame + ACC_W'(1);
            end else begin
                exp_bin_next   = bus.cnt_sync_in + CW'(1);
                frame_cnt_next = cur_frame;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_bin_reg   <= '0;
            frame_cnt_reg <= '0;
            len_q_reg     <= '0;
            sync_err_reg  <= 1'b0;
        end else begin
            exp_bin_reg   <= exp_bin_next;
            frame_cnt_reg <= frame_cnt_next;
            len_q_reg     <= len_q_next;
            sync_err_reg  <= sync_err_next;
        end
    end

    assign tag_in = {take, start, cur_last, bus.cnt_sync_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT - 1; i++) begin
                tag_reg[i] <= '0;
            end
            s1_first_reg <= 1'b0;
            s1_pwr_reg   <= '0;
        end else begin
            tag_reg[0] <= tag_in;
            for (int i = 1; i < PIPE_LAT - 1; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
            s1_first_reg <= cur_first;
            s1_pwr_reg   <= bus.pwr_in;
        end
    end

    acc_ram_sdp #(
        .DEPTH (FFT_POINT),
        .AW    (CW),
        .DW    (SUM_W)
    ) u_ram (
        .clk   (clk),
        .we    (s2_valid),
        .waddr (s2_bin),
        .wdata (s2_sum_reg),
        .re    (take),
        .raddr (bus.cnt_sync_in),
        .rdata (rd_data)
    );

    // First spectrum of an integration ignores whatever the RAM holds.
    always_comb begin
        if (s1_first_reg) begin
            add_res = {1'b0, SUM_W'(s1_pwr_reg)};
        end else begin
            add_res = sat_add(rd_data, SUM_W'(s1_pwr_reg));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_sum_reg <= '0;
            s2_sat_reg <= 1'b0;
        end else begin
            s2_sum_reg <= add_res[SUM_W-1:0];
            s2_sat_reg <= add_res[SUM_W];
        end
    end

    assign tag_s2   = tag_reg[PIPE_LAT-2];
    assign s2_valid = tag_s2[T_VALID];
    assign s2_bin   = tag_s2[CW-1:0];
    assign s2_fire  = s2_valid && tag_s2[T_LAST];

    always_ff @(posedge clk) begin
        if (rst) begin
            para_out_reg <= '0;
            en_out_reg   <= 1'b0;
            cnt_out_reg  <= '0;
            acc_done_reg <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            en_out_reg   <= s2_fire;
            para_out_reg <= s2_fire ? s2_sum_reg : '0;
            cnt_out_reg  <= s2_fire ? s2_bin : '0;
            acc_done_reg <= s2_fire && (s2_bin == LAST_BIN);
            // Clear and set happen in the output stage so the flag lines up
            // with acc_done of the spectrum that saturated.
            if (s2_valid) begin
                ovf_reg <= (ovf_reg && !tag_s2[T_START]) || s2_sat_reg;
            end
        end
    end

    assign bus.para_out     = para_out_reg;
    assign bus.en_sync_out  = en_out_reg;
    assign bus.cnt_sync_out = cnt_out_reg;
    assign bus.acc_done     = acc_done_reg;
    assign bus.ovf          = ovf_reg;
    assign bus.sync_err     = sync_err_reg;

endmodule

// File: tb/tb_spec_accum_48bit.sv
// Scoreboarded bench for spec_accum_48bit: every driven cycle queues its
// expected output, which is compared against the DUT three cycles later.
module tb_spec_accum_48bit;
    import spec_accum_pkg::*;

    localparam int BW = 7;
    localparam int FP = 512;
    localparam int IW = 48;
    localparam int AW = 16;
    localparam int CW = BW + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spec_accum_if #(.CW(CW), .IN_W(IW), .ACC_W(AW)) bus ();

    spec_accum_48bit #(
        .BITWIDTH  (BW),
        .FFT_POINT (FP),
        .IN_W      (IW),
        .ACC_W     (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          en;
        logic [CW-1:0] cnt;
        logic [47:0]   para;
        logic          done;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // One clock cycle: compare the output due now, then drive this cycle's
    // input and queue what it must produce.
    task automatic drive(input logic en, input int cnt, input logic [IW-1:0] pwr,
                         input logic out_en, input logic [47:0] out_para);
        exp_t e;
        exp_t p;
        @(posedge clk);
        #1;
        if (sb.size() >= 3) begin
            p = sb.pop_front();
            check_val("en_out", 64'(bus.en_sync_out), 64'(p.en));
            check_val("para",   64'(bus.para_out),    64'(p.para));
            check_val("done",   64'(bus.acc_done),    64'(p.done));
            if (p.en) begin
                check_val("cnt_out", 64'(bus.cnt_sync_out), 64'(p.cnt));
            end
        end
        bus.en_sync_in  = en;
        bus.cnt_sync_in = CW'(cnt);
        bus.pwr_in      = pwr;
        e.en   = out_en;
        e.cnt  = CW'(cnt);
        e.para = out_en ? out_para : 48'd0;
        e.done = out_en && (cnt == FP - 1);
        sb.push_back(e);
    endtask

    task automatic drain();
        repeat (3) drive(1'b0, 0, '0, 1'b0, 48'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.en_sync_in = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_en",   64'(bus.en_sync_out),  64'd0);
        check_val("rst_para", 64'(bus.para_out),     64'd0);
        check_val("rst_cnt",  64'(bus.cnt_sync_out), 64'd0);
        check_val("rst_done", 64'(bus.acc_done),     64'd0);
        check_val("rst_ovf",  64'(bus.ovf),          64'd0);
        check_val("rst_serr", 64'(bus.sync_err),     64'd0);
        rst = 1'b0;
        sb.delete();
        repeat (3) sb.push_back(exp_t'(0));
    endtask

    initial begin
        bus.en_sync_in  = 1'b0;
        bus.cnt_sync_in = '0;
        bus.pwr_in      = '0;
        bus.acc_len     = '0;
        do_reset();
        $display("reset: outputs idle");

        // Basic 4-spectrum integration; acc_len changes mid-run must not matter.
        bus.acc_len = 16'd4;
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < FP; b++) begin
                if (s == 1 && b == 10) bus.acc_len = 16'd1;
                drive(1'b1, b, IW'(b + 1), s == 3, 48'(4 * (b + 1)));
            end
        end
        drain();
        check_val("t1_ovf",  64'(bus.ovf),      64'd0);
        check_val("t1_serr", 64'(bus.sync_err), 64'd0);
        $display("basic: acc_len=4 spectrum checked");

        // acc_len=0 behaves as 1: every spectrum passes straight through.
        bus.acc_len = 16'd0;
        for (int s = 0; s < 2; s++) begin
            for (int b = 0; b < FP; b++) begin
                drive(1'b1, b, IW'(32'hFFFF_FFFF), 1'b1, 48'h0000_FFFF_FFFF);
            end
        end
        drain();
        $display("acc_len=0: two pass-through spectra checked");

        // Gapped input keeps its spacing on the output.
        bus.acc_len = 16'd2;
        for (int s = 0; s < 2; s++) begin
            for (int b = 0; b < FP; b++) begin
                drive(1'b1, b, IW'(7), s == 1, 48'd14);
                drive(1'b0, 0, '0, 1'b0, 48'd0);
            end
        end
        drain();
        $display("gapped: acc_len=2 spectrum checked");

        // Bin jump 100 -> 102 in spectrum 2 of 3: discard, then wait for bin 0.
        bus.acc_len = 16'd3;
        for (int b = 0; b < FP; b++) drive(1'b1, b, IW'(1), 1'b0, 48'd0);
        for (int b = 0; b <= 100; b++) drive(1'b1, b, IW'(1), 1'b0, 48'd0);
        drive(1'b1, 102, IW'(1), 1'b0, 48'd0);
        for (int b = 103; b <= 110; b++) drive(1'b1, b, IW'(1), 1'b0, 48'd0);
        drain();
        check_val("t4_serr", 64'(bus.sync_err), 64'd1);
        // Fresh run; an out-of-order bin 0 after bin 20 restarts it on the spot.
        bus.acc_len = 16'd2;
        for (int b = 0; b <= 20; b++) drive(1'b1, b, IW'(1), 1'b0, 48'd0);
        for (int s = 0; s < 2; s++) begin
            for (int b = 0; b < FP; b++) drive(1'b1, b, IW'(1), s == 1, 48'd2);
        end
        drain();
        check_val("t4_serr_sticky", 64'(bus.sync_err), 64'd1);
        $display("sync error: discard and restart checked");

        // Bin 5 reaches exactly ACC_MAX after 2 spectra, saturates in the last.
        bus.acc_len = 16'd3;
        for (int s = 0; s < 3; s++) begin
            for (int b = 0; b < FP; b++) begin
                if (s == 2 && b == 0) check_val("t5_ovf_pre", 64'(bus.ovf), 64'd0);
                if (b == 5) begin
                    drive(1'b1, b, (s == 0) ? 48'h8000_0000_0000 :
                                   (s == 1) ? 48'h7FFF_FFFF_FFFF : 48'd1,
                          s == 2, ACC_MAX);
                end else begin
                    drive(1'b1, b, IW'(1), s == 2, 48'd3);
                end
            end
        end
        drain();
        check_val("t5_ovf_done", 64'(bus.ovf), 64'd1);
        bus.acc_len = 16'd1;
        for (int b = 0; b < FP; b++) drive(1'b1, b, IW'(b), 1'b1, 48'(b));
        drain();
        check_val("t5_ovf_clr", 64'(bus.ovf), 64'd0);
        $display("saturation: clamp and ovf lifetime checked");

        // Reset in the middle of spectrum 3 of 4, then a clean run.
        check_val("t6_serr_pre", 64'(bus.sync_err), 64'd1);
        bus.acc_len = 16'd4;
        for (int s = 0; s < 2; s++) begin
            for (int b = 0; b < FP; b++) drive(1'b1, b, IW'(3), 1'b0, 48'd0);
        end
        for (int b = 0; b <= 200; b++) drive(1'b1, b, IW'(3), 1'b0, 48'd0);
        do_reset();
        bus.acc_len = 16'd4;
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < FP; b++) drive(1'b1, b, IW'(3), s == 3, 48'd12);
        end
        drain();
        $display("reset mid-run: flush and fresh integration checked");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
